// File: rtl/parking_pkg.sv
// Shared types and constants for the parking entry path (keypad auth + slot allocator).
`ifndef PARKING_SLOTS
`define PARKING_SLOTS 8
`endif

package parking_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_CHECK   = 3'd2,
        ST_RESULT  = 3'd3,
        ST_LOCKOUT = 3'd4
    } auth_state_e;

    localparam int unsigned PIN_DIGITS = 4;
    localparam int unsigned PIN_W      = 16;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned BCD_MAX    = 9;

    // Flat-number width; the allocator downstream uses the same expression.
    function automatic int unsigned flat_w(input int unsigned n);
        return n + 1;
    endfunction

endpackage

// File: rtl/auth_pin_table.sv
// Per-flat PIN register file: one qualified write port, one combinational read port.
module auth_pin_table
    import parking_pkg::*;
#(
    parameter int unsigned N = `PARKING_SLOTS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [flat_w(N)-1:0]   waddr,
    input  logic [PIN_W-1:0]       wdata,
    input  logic [flat_w(N)-1:0]   raddr,
    output logic [PIN_W-1:0]       rdata_c
);

    localparam int unsigned FW = flat_w(N);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [PIN_W-1:0] mem_q [N];
    logic [PIN_W-1:0] mem_d [N];
    logic [IW-1:0]    widx;
    logic [IW-1:0]    ridx;
    logic             waddr_ok;

    // Flats are 1-based; storage is 0-based.
    assign widx     = IW'(waddr - FW'(1));
    assign ridx     = IW'(raddr - FW'(1));
    assign waddr_ok = (waddr != '0) && (waddr <= FW'(N));
    assign rdata_c  = mem_q[ridx];

    always_comb begin
        mem_d = mem_q;
        if (we && waddr_ok) begin
            mem_d[widx] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/resident_auth_gate.sv
// Keypad PIN authentication ahead of reserved-parking entry: collects 4 BCD digits,
// checks them against the per-flat table, and locks the keypad after repeated failures.
module resident_auth_gate
    import parking_pkg::*;
#(
    parameter int unsigned N              = `PARKING_SLOTS,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCK_CYCLES    = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    input  logic [flat_w(N)-1:0]             req_flat,
    input  logic                             key_valid,
    input  logic [DIGIT_W-1:0]               key_digit,
    input  logic                             pw_we,
    input  logic [flat_w(N)-1:0]             pw_addr,
    input  logic [PIN_W-1:0]                 pw_data,
    output logic                             ready,
    output logic                             out_valid,
    output logic                             pwd_flag,
    output logic [flat_w(N)-1:0]             flat_number,
    output logic                             locked,
    output logic                             timeout,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt
);

    localparam int unsigned FW = flat_w(N);
    localparam int unsigned CW = $clog2(MAX_TRIES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);
    localparam int unsigned DW = $clog2(PIN_DIGITS + 1);

    auth_state_e      state_q, state_d;
    logic [FW-1:0]    flat_q, flat_d;
    logic [PIN_W-1:0] entry_q, entry_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic             bad_q, bad_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [LW-1:0]    lock_q, lock_d;
    logic             chk_ph_q, chk_ph_d;
    logic             match_q, match_d;
    logic [CW-1:0]    fail_q, fail_d;
    logic             ready_q, ready_d;
    logic             out_valid_q, out_valid_d;
    logic             pwd_q, pwd_d;
    logic             timeout_q, timeout_d;
    logic             locked_q, locked_d;

    logic [PIN_W-1:0] rd_pin_c;
    logic             tbl_we_c;
    logic             flat_ok_c;

    // Table is only writable while no attempt is in flight.
    assign tbl_we_c  = pw_we && (state_q == ST_IDLE);
    assign flat_ok_c = (req_flat != '0) && (req_flat <= FW'(N));

    auth_pin_table #(.N(N)) u_table (
        .clk     (clk),
        .rst     (rst),
        .we      (tbl_we_c),
        .waddr   (pw_addr),
        .wdata   (pw_data),
        .raddr   (flat_q),
        .rdata_c (rd_pin_c)
    );

    always_comb begin
        state_d   = state_q;
        flat_d    = flat_q;
        entry_d   = entry_q;
        dcnt_d    = dcnt_q;
        bad_d     = bad_q;
        timer_d   = timer_q;
        lock_d    = lock_q;
        chk_ph_d  = chk_ph_q;
        match_d   = match_q;
        fail_d    = fail_q;
        pwd_d     = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    flat_d = req_flat;
                    if (flat_ok_c) begin
                        entry_d = '0;
                        dcnt_d  = '0;
                        bad_d   = 1'b0;
                        timer_d = '0;
                        state_d = ST_COLLECT;
                    end else begin
                        state_d = ST_RESULT;
                    end
                end
            end
            ST_COLLECT: begin
                if (timer_q == TW'(TIMEOUT_CYCLES)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_RESULT;
                end else if (key_valid) begin
                    entry_d = {entry_q[PIN_W-DIGIT_W-1:0], key_digit};
                    bad_d   = bad_q | (key_digit > DIGIT_W'(BCD_MAX));
                    timer_d = '0;
                    dcnt_d  = dcnt_q + DW'(1);
                    if (dcnt_q == DW'(PIN_DIGITS - 1)) begin
                        chk_ph_d = 1'b0;
                        state_d  = ST_CHECK;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            // Two cycles: register the compare, then commit the verdict.
            ST_CHECK: begin
                if (!chk_ph_q) begin
                    match_d  = (entry_q == rd_pin_c) && !bad_q;
                    chk_ph_d = 1'b1;
                end else begin
                    state_d = ST_RESULT;
                    if (match_q) begin
                        fail_d = '0;
                        pwd_d  = 1'b1;
                    end else if (fail_q < CW'(MAX_TRIES)) begin
                        fail_d = fail_q + CW'(1);
                    end
                end
            end
            ST_RESULT: begin
                if (fail_q == CW'(MAX_TRIES)) begin
                    lock_d  = '0;
                    state_d = ST_LOCKOUT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (lock_q == LW'(LOCK_CYCLES - 1)) begin
                    fail_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    lock_d = lock_q + LW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d     = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_RESULT);
        locked_d    = (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            flat_q      <= '0;
            entry_q     <= '0;
            dcnt_q      <= '0;
            bad_q       <= 1'b0;
            timer_q     <= '0;
            lock_q      <= '0;
            chk_ph_q    <= 1'b0;
            match_q     <= 1'b0;
            fail_q      <= '0;
            ready_q     <= 1'b1;
            out_valid_q <= 1'b0;
            pwd_q       <= 1'b0;
            timeout_q   <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            flat_q      <= flat_d;
            entry_q     <= entry_d;
            dcnt_q      <= dcnt_d;
            bad_q       <= bad_d;
            timer_q     <= timer_d;
            lock_q      <= lock_d;
            chk_ph_q    <= chk_ph_d;
            match_q     <= match_d;
            fail_q      <= fail_d;
            ready_q     <= ready_d;
            out_valid_q <= out_valid_d;
            pwd_q       <= pwd_d;
            timeout_q   <= timeout_d;
            locked_q    <= locked_d;
        end
    end

    assign ready       = ready_q;
    assign out_valid   = out_valid_q;
    assign pwd_flag    = pwd_q;
    assign flat_number = flat_q;
    assign locked      = locked_q;
    assign timeout     = timeout_q;
    assign fail_cnt    = fail_q;

endmodule

// File: tb/tb_resident_auth_gate.sv
// Directed bench for resident_auth_gate: good/bad PINs, lockout, invalid flats, timeout, reset.
module tb_resident_auth_gate;

    localparam int unsigned N              = 8;
    localparam int unsigned MAX_TRIES      = 3;
    localparam int unsigned LOCK_CYCLES    = 1024;
    localparam int unsigned TIMEOUT_CYCLES = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [N:0]  req_flat = '0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_digit = '0;
    logic        pw_we = 1'b0;
    logic [N:0]  pw_addr = '0;
    logic [15:0] pw_data = '0;
    logic        ready;
    logic        out_valid;
    logic        pwd_flag;
    logic [N:0]  flat_number;
    logic        locked;
    logic        timeout;
    logic [1:0]  fail_cnt;

    int vectors     = 0;
    int miscompares = 0;

    resident_auth_gate #(
        .N              (N),
        .MAX_TRIES      (MAX_TRIES),
        .LOCK_CYCLES    (LOCK_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_flat    (req_flat),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .pw_we       (pw_we),
        .pw_addr     (pw_addr),
        .pw_data     (pw_data),
        .ready       (ready),
        .out_valid   (out_valid),
        .pwd_flag    (pwd_flag),
        .flat_number (flat_number),
        .locked      (locked),
        .timeout     (timeout),
        .fail_cnt    (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},     32'(ready),       32'd1);
        check({tag, "_out_valid"}, 32'(out_valid),   32'd0);
        check({tag, "_pwd_flag"},  32'(pwd_flag),    32'd0);
        check({tag, "_flat"},      32'(flat_number), 32'd0);
        check({tag, "_locked"},    32'(locked),      32'd0);
        check({tag, "_timeout"},   32'(timeout),     32'd0);
        check({tag, "_fail_cnt"},  32'(fail_cnt),    32'd0);
    endtask

    // One full attempt; optionally fires a table write during the first digit.
    task automatic attempt(input logic [N:0] flat, input logic [15:0] pin, input logic exp_pwd,
                           input logic [1:0] exp_fail, input logic exp_lock, input logic poke);
        req_valid = 1'b1;
        req_flat  = flat;
        step();
        req_valid = 1'b0;
        check("ready_drop", 32'(ready), 32'd0);
        for (int i = 3; i >= 0; i--) begin
            key_valid = 1'b1;
            key_digit = pin[i*4 +: 4];
            if (poke && i == 3) begin
                pw_we   = 1'b1;
                pw_addr = flat;
                pw_data = 16'h9999;
            end
            step();
            pw_we = 1'b0;
        end
        key_valid = 1'b0;
        check("latency_t0", 32'(out_valid), 32'd0);
        step();
        check("latency_t1", 32'(out_valid), 32'd0);
        step();
        check("out_valid",   32'(out_valid),   32'd1);
        check("pwd_flag",    32'(pwd_flag),    32'(exp_pwd));
        check("flat_number", 32'(flat_number), 32'(flat));
        check("fail_cnt",    32'(fail_cnt),    32'(exp_fail));
        check("timeout_low", 32'(timeout),     32'd0);
        step();
        check("out_valid_pulse", 32'(out_valid), 32'd0);
        check("locked_after",    32'(locked),    32'(exp_lock));
        check("ready_after",     32'(ready),     32'(!exp_lock));
    endtask

    task automatic bad_flat(input logic [N:0] flat, input logic [1:0] exp_fail);
        req_valid = 1'b1;
        req_flat  = flat;
        step();
        req_valid = 1'b0;
        check("badflat_out_valid", 32'(out_valid),   32'd1);
        check("badflat_pwd",       32'(pwd_flag),    32'd0);
        check("badflat_flat",      32'(flat_number), 32'(flat));
        check("badflat_fail_cnt",  32'(fail_cnt),    32'(exp_fail));
        check("badflat_ready",     32'(ready),       32'd0);
        step();
        check("badflat_pulse",     32'(out_valid),   32'd0);
        check("badflat_ready_back",32'(ready),       32'd1);
    endtask

    initial begin
        int  n;
        logic saw;

        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Program flat 3; a write to flat 0 must be dropped harmlessly.
        pw_we   = 1'b1;
        pw_addr = 9'd3;
        pw_data = 16'h1234;
        step();
        pw_addr = 9'd0;
        pw_data = 16'hFFFF;
        step();
        pw_we = 1'b0;

        attempt(9'd3, 16'h1234, 1'b1, 2'd0, 1'b0, 1'b0);

        // Three failures lead to lockout.
        attempt(9'd3, 16'h5555, 1'b0, 2'd1, 1'b0, 1'b0);
        attempt(9'd3, 16'h5555, 1'b0, 2'd2, 1'b0, 1'b0);
        attempt(9'd3, 16'h5555, 1'b0, 2'd3, 1'b1, 1'b0);
        n   = 1;
        saw = 1'b0;
        req_valid = 1'b1;
        req_flat  = 9'd3;
        key_valid = 1'b1;
        key_digit = 4'd1;
        for (int c = 0; c < 2000; c++) begin
            step();
            if (c == 4) begin
                req_valid = 1'b0;
                key_valid = 1'b0;
            end
            if (out_valid) saw = 1'b1;
            if (!locked) break;
            n++;
        end
        check("lock_len",       32'(n),        32'(LOCK_CYCLES));
        check("lock_no_result", 32'(saw),      32'd0);
        check("post_lock_ready",32'(ready),    32'd1);
        check("post_lock_fail", 32'(fail_cnt), 32'd0);
        step();

        // Invalid flats leave the failure count alone.
        attempt(9'd3, 16'h5555, 1'b0, 2'd1, 1'b0, 1'b0);
        bad_flat(9'd0, 2'd1);
        bad_flat(9'(N + 1), 2'd1);

        // Timeout after two digits.
        req_valid = 1'b1;
        req_flat  = 9'd3;
        step();
        req_valid = 1'b0;
        key_valid = 1'b1;
        key_digit = 4'd1;
        step();
        key_digit = 4'd2;
        step();
        key_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 5000; c++) begin
            step();
            n++;
            if (out_valid) break;
        end
        check("timeout_latency", 32'(n),           32'(TIMEOUT_CYCLES + 1));
        check("timeout_flag",    32'(timeout),     32'd1);
        check("timeout_pwd",     32'(pwd_flag),    32'd0);
        check("timeout_fail",    32'(fail_cnt),    32'd1);
        check("timeout_flat",    32'(flat_number), 32'd3);
        step();
        check("timeout_pulse",   32'(timeout),     32'd0);
        check("timeout_ready",   32'(ready),       32'd1);

        // Non-BCD digit fails; write during COLLECT is dropped so 1234 still works.
        attempt(9'd3, 16'h12A4, 1'b0, 2'd2, 1'b0, 1'b1);
        attempt(9'd3, 16'h1234, 1'b1, 2'd0, 1'b0, 1'b0);

        // Reset in the middle of COLLECT.
        attempt(9'd3, 16'h5555, 1'b0, 2'd1, 1'b0, 1'b0);
        req_valid = 1'b1;
        req_flat  = 9'd3;
        step();
        req_valid = 1'b0;
        key_valid = 1'b1;
        key_digit = 4'd1;
        step();
        key_digit = 4'd2;
        step();
        key_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        step();
        step();
        rst = 1'b0;
        saw = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (out_valid) saw = 1'b1;
        end
        check("midreset_no_result", 32'(saw), 32'd0);
        attempt(9'd3, 16'h1234, 1'b0, 2'd1, 1'b0, 1'b0);
        attempt(9'd3, 16'h0000, 1'b1, 2'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
